pattern_gen: RTL and testbench

- Parametrised, mode-selectable pixel-colour source that sits between the VGA video driver's x/y scan outputs and its r/g/b inputs.
- Replaces ad-hoc per-top colour assignments with one reusable generator providing these modes:
  - solid colour
  - horizontal and vertical gradients
  - 8-bar colour bars
  - checkerboard
  - bouncing box animated once per frame
  - legacy x/y debug pattern
- Mode changes and animation updates take effect only at frame boundaries, so no tearing occurs.

---
 rtl/pattern_gen.sv | 173 +++++++++++++++++
 tb/tb_pattern_gen.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pattern_gen.sv
// Mode-selectable pixel colour source for the VGA scan-out path.
// Two pipeline stages: classify the pixel, then pick its colour.
module pattern_gen #(
    parameter int WIDTH     = 640,
    parameter int HEIGHT    = 480,
    parameter int COLOR_W   = 8,
    parameter int TILE_LOG2 = 5,
    parameter int BOX       = 32,
    parameter int STEP      = 4,
    parameter int X_W       = $clog2(WIDTH),
    parameter int Y_W       = $clog2(HEIGHT)
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [X_W-1:0]     x,
    input  logic [Y_W-1:0]     y,
    input  logic [2:0]         mode_req,
    input  logic [COLOR_W-1:0] fg_r,
    input  logic [COLOR_W-1:0] fg_g,
    input  logic [COLOR_W-1:0] fg_b,
    input  logic               pause,
    output logic [COLOR_W-1:0] r,
    output logic [COLOR_W-1:0] g,
    output logic [COLOR_W-1:0] b,
    output logic [2:0]         mode_active,
    output logic [15:0]        frame_count
);
    localparam logic [2:0] M_SOLID = 3'd0, M_HGRAD = 3'd1, M_VGRAD = 3'd2, M_BARS = 3'd3;
    localparam logic [2:0] M_CHECK = 3'd4, M_BOX = 3'd5, M_LEGACY = 3'd6;
    localparam int XSH = (X_W > COLOR_W) ? X_W - COLOR_W : 0;
    localparam int YSH = (Y_W > COLOR_W) ? Y_W - COLOR_W : 0;
    localparam logic [X_W:0]   X_LIM  = (X_W+1)'(WIDTH);
    localparam logic [X_W:0]   X_RUN  = (X_W+1)'(BOX + STEP);
    localparam logic [X_W:0]   X_BOX  = (X_W+1)'(BOX);
    localparam logic [X_W-1:0] X_MAX  = X_W'(WIDTH - BOX);
    localparam logic [X_W-1:0] X_STEP = X_W'(STEP);
    localparam logic [X_W-1:0] BAR_W  = X_W'(WIDTH / 8);
    localparam logic [Y_W:0]   Y_LIM  = (Y_W+1)'(HEIGHT);
    localparam logic [Y_W:0]   Y_RUN  = (Y_W+1)'(BOX + STEP);
    localparam logic [Y_W:0]   Y_BOX  = (Y_W+1)'(BOX);
    localparam logic [Y_W-1:0] Y_MAX  = Y_W'(HEIGHT - BOX);
    localparam logic [Y_W-1:0] Y_STEP = Y_W'(STEP);

    logic [Y_W-1:0]     r_prev_y;
    logic [2:0]         r_mode;
    logic [15:0]        r_fc;
    logic [X_W-1:0]     r_bx, w_bx_nxt, w_bar_q;
    logic [Y_W-1:0]     r_by, w_by_nxt;
    logic               r_dx_neg, r_dy_neg, w_dx_nxt, w_dy_nxt;
    logic               w_tick, w_in_box, w_oor, w_par;
    logic [2:0]         w_bar;
    logic [X_W-1:0]     r_s1_x;
    logic [Y_W-1:0]     r_s1_y;
    logic [2:0]         r_s1_bar, r_s1_mode;
    logic               r_s1_par, r_s1_in, r_s1_oor;
    logic [COLOR_W-1:0] r_s1_fr, r_s1_fg, r_s1_fb;
    logic [COLOR_W-1:0] w_r, w_g, w_b, w_xg, w_yg, r_r, r_g, r_b;

    assign w_tick = (y == '0) && (r_prev_y != '0);

    // Each axis bounces independently; the edge frame clamps and flips.
    always_comb begin
        w_bx_nxt = r_bx;
        w_dx_nxt = r_dx_neg;
        w_by_nxt = r_by;
        w_dy_nxt = r_dy_neg;
        if (!r_dx_neg) begin
            if ({1'b0, r_bx} + X_RUN > X_LIM) begin
                w_bx_nxt = X_MAX;
                w_dx_nxt = 1'b1;
            end else
                w_bx_nxt = r_bx + X_STEP;
        end else if (r_bx < X_STEP) begin
            w_bx_nxt = '0;
            w_dx_nxt = 1'b0;
        end else
            w_bx_nxt = r_bx - X_STEP;
        if (!r_dy_neg) begin
            if ({1'b0, r_by} + Y_RUN > Y_LIM) begin
                w_by_nxt = Y_MAX;
                w_dy_nxt = 1'b1;
            end else
                w_by_nxt = r_by + Y_STEP;
        end else if (r_by < Y_STEP) begin
            w_by_nxt = '0;
            w_dy_nxt = 1'b0;
        end else
            w_by_nxt = r_by - Y_STEP;
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_prev_y <= '0;
            r_mode   <= '0;
            r_fc     <= '0;
            r_bx     <= '0;
            r_by     <= '0;
            r_dx_neg <= 1'b0;
            r_dy_neg <= 1'b0;
        end else begin
            r_prev_y <= y;
            if (w_tick) begin
                r_mode <= mode_req;
                r_fc   <= r_fc + 16'd1;
                if (!pause) begin
                    r_bx     <= w_bx_nxt;
                    r_dx_neg <= w_dx_nxt;
                    r_by     <= w_by_nxt;
                    r_dy_neg <= w_dy_nxt;
                end
            end
        end
    end

    assign w_bar_q  = x / BAR_W;
    assign w_bar    = (w_bar_q > X_W'(7)) ? 3'd7 : w_bar_q[2:0];
    assign w_par    = x[TILE_LOG2] ^ y[TILE_LOG2];
    assign w_oor    = ({1'b0, x} >= X_LIM) || ({1'b0, y} >= Y_LIM);
    assign w_in_box = ({1'b0, x} >= {1'b0, r_bx}) && ({1'b0, x} < {1'b0, r_bx} + X_BOX) &&
                      ({1'b0, y} >= {1'b0, r_by}) && ({1'b0, y} < {1'b0, r_by} + Y_BOX);

    // Stage 1 snapshots mode and fg too, so a pixel sees one consistent frame state.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_s1_x <= '0; r_s1_y <= '0; r_s1_bar <= '0; r_s1_mode <= '0;
            r_s1_par <= 1'b0; r_s1_in <= 1'b0; r_s1_oor <= 1'b0;
            r_s1_fr <= '0; r_s1_fg <= '0; r_s1_fb <= '0;
        end else begin
            r_s1_x <= x; r_s1_y <= y; r_s1_bar <= w_bar; r_s1_mode <= r_mode;
            r_s1_par <= w_par; r_s1_in <= w_in_box; r_s1_oor <= w_oor;
            r_s1_fr <= fg_r; r_s1_fg <= fg_g; r_s1_fb <= fg_b;
        end
    end

    assign w_xg = COLOR_W'(r_s1_x >> XSH);
    assign w_yg = COLOR_W'(r_s1_y >> YSH);

    always_comb begin
        w_r = '0;
        w_g = '0;
        w_b = '0;
        if (!r_s1_oor) begin
            case (r_s1_mode)
                M_SOLID:  begin w_r = r_s1_fr; w_g = r_s1_fg; w_b = r_s1_fb; end
                M_HGRAD:  begin w_r = w_xg; w_g = w_xg; w_b = w_xg; end
                M_VGRAD:  begin w_r = w_yg; w_g = w_yg; w_b = w_yg; end
                M_BARS: begin
                    w_r = {COLOR_W{~r_s1_bar[1]}};
                    w_g = {COLOR_W{~r_s1_bar[2]}};
                    w_b = {COLOR_W{~r_s1_bar[0]}};
                end
                M_CHECK:  if (!r_s1_par) begin w_r = r_s1_fr; w_g = r_s1_fg; w_b = r_s1_fb; end
                M_BOX:    if (r_s1_in) begin w_r = r_s1_fr; w_g = r_s1_fg; w_b = r_s1_fb; end
                M_LEGACY: begin w_r = r_s1_fr; w_g = COLOR_W'(r_s1_x); w_b = COLOR_W'(r_s1_y); end
                default:  ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_r <= '0; r_g <= '0; r_b <= '0;
        end else begin
            r_r <= w_r; r_g <= w_g; r_b <= w_b;
        end
    end

    assign r           = r_r;
    assign g           = r_g;
    assign b           = r_b;
    assign mode_active = r_mode;
    assign frame_count = r_fc;
endmodule

// File: tb/tb_pattern_gen.sv
// Randomised scoreboard bench for pattern_gen against a closed-form frame/pixel model.
module tb_pattern_gen;
    localparam int WIDTH = 640, HEIGHT = 480, COLOR_W = 8, TILE_LOG2 = 5, BOX = 32, STEP = 4;
    localparam int X_W = $clog2(WIDTH), Y_W = $clog2(HEIGHT);
    localparam int ONES = (1 << COLOR_W) - 1;

    logic               CLOCK_50 = 1'b0, reset = 1'b0, pause = 1'b0;
    logic [X_W-1:0]     x = '0;
    logic [Y_W-1:0]     y = '0;
    logic [2:0]         mode_req = '0, mode_active;
    logic [COLOR_W-1:0] fg_r = '0, fg_g = '0, fg_b = '0, r, g, b;
    logic [15:0]        frame_count;

    pattern_gen #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .COLOR_W(COLOR_W), .TILE_LOG2(TILE_LOG2),
                  .BOX(BOX), .STEP(STEP)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .x(x), .y(y), .mode_req(mode_req),
        .fg_r(fg_r), .fg_g(fg_g), .fg_b(fg_b), .pause(pause),
        .r(r), .g(g), .b(b), .mode_active(mode_active), .frame_count(frame_count));

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct packed { logic [COLOR_W-1:0] r, g, b; } rgb_t;
    rgb_t q[$];
    int checks = 0, errors = 0;
    int m_prev_y = 0, m_mode = 0, m_fc = 0, m_adv = 0;
    // bars as {r,g,b} on/off: white yellow cyan green magenta red blue black
    logic [2:0] bar_rgb [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Box position after n advances: a triangle wave that dwells one frame at each end.
    function automatic int box_pos(int n, int d);
        int last, k;
        last = (d - BOX) / STEP;
        k = n % (2 * (last + 1));
        return (k <= last) ? STEP * k : STEP * (2 * last + 1 - k);
    endfunction

    function automatic rgb_t model_px(int px, int py);
        rgb_t fg, o;
        int bx, by, bar;
        fg = '{fg_r, fg_g, fg_b};
        o = '0;
        bx = box_pos(m_adv, WIDTH);
        by = box_pos(m_adv, HEIGHT);
        if (px >= WIDTH || py >= HEIGHT) return o;
        case (m_mode)
            0: o = fg;
            1: o = '{COLOR_W'(px / 4), COLOR_W'(px / 4), COLOR_W'(px / 4)};
            2: o = '{COLOR_W'(py / 2), COLOR_W'(py / 2), COLOR_W'(py / 2)};
            3: begin
                bar = px / (WIDTH / 8);
                if (bar > 7) bar = 7;
                o = '{COLOR_W'(bar_rgb[bar][2] * ONES), COLOR_W'(bar_rgb[bar][1] * ONES),
                      COLOR_W'(bar_rgb[bar][0] * ONES)};
            end
            4: if (((px >> TILE_LOG2) + (py >> TILE_LOG2)) % 2 == 0) o = fg;
            5: if (px >= bx && px < bx + BOX && py >= by && py < by + BOX) o = fg;
            6: o = '{fg_r, COLOR_W'(px % 256), COLOR_W'(py % 256)};
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic step();
        rgb_t e;
        bit tk;
        e = model_px(int'(x), int'(y));
        tk = (y == 0) && (m_prev_y != 0);
        @(posedge CLOCK_50);
        q.push_back(e);
        if (tk) begin
            m_mode = int'(mode_req);
            m_fc = (m_fc + 1) % 65536;
            if (!pause) m_adv++;
        end
        m_prev_y = int'(y);
        #1;
    endtask

    task automatic pix(int px, int py);
        x = X_W'(px);
        y = Y_W'(py);
        step();
    endtask

    task automatic rnd_px(int n);
        for (int i = 0; i < n; i++) pix($urandom_range(0, WIDTH + 40), $urandom_range(1, HEIGHT + 20));
    endtask

    task automatic tick();
        pix($urandom_range(0, WIDTH - 1), $urandom_range(1, HEIGHT - 1));
        pix($urandom_range(0, WIDTH - 1), 0);
    endtask

    task automatic model_clear();
        q.delete();
        m_prev_y = 0; m_mode = 0; m_fc = 0; m_adv = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_clear();
        repeat (3) @(posedge CLOCK_50);
        #1 reset = 1'b1;
    endtask

    task automatic set_fg(int rr, int gg, int bb);
        fg_r = COLOR_W'(rr); fg_g = COLOR_W'(gg); fg_b = COLOR_W'(bb);
    endtask

    // Output after edge k belongs to the pixel captured at edge k-1.
    always @(negedge CLOCK_50) begin
        rgb_t e;
        if (!reset) begin
            chk("rst_r", int'(r), 0); chk("rst_g", int'(g), 0); chk("rst_b", int'(b), 0);
            chk("rst_mode", int'(mode_active), 0); chk("rst_fc", int'(frame_count), 0);
        end else begin
            chk("mode_active", int'(mode_active), m_mode);
            chk("frame_count", int'(frame_count), m_fc);
            if (q.size() >= 2) begin
                e = q.pop_front();
                chk("px_r", int'(r), int'(e.r));
                chk("px_g", int'(g), int'(e.g));
                chk("px_b", int'(b), int'(e.b));
            end
        end
    end

    initial begin
        int bx, by;
        do_reset();
        mode_req = 3'd0; set_fg('h12, 'h34, 'h56);
        tick(); pix(10, 10); rnd_px(20);

        mode_req = 3'd3; tick();
        pix(0, 5); pix(79, 5); pix(80, 5); pix(639, 5); pix(640, 5);
        rnd_px(30);

        mode_req = 3'd4; set_fg(ONES, ONES, ONES); tick();
        pix(0, 0); pix(32, 0); pix(32, 32); pix(31, 31); rnd_px(30);

        for (int m = 0; m < 8; m++) begin
            mode_req = 3'(m);
            set_fg($urandom_range(0, ONES), $urandom_range(0, ONES), $urandom_range(0, ONES));
            tick(); rnd_px(25);
        end

        mode_req = 3'd1; tick(); pix(100, 200); pix(300, 200);
        mode_req = 3'd2; pix(400, 200); pix(500, 201); pix(600, 202);
        tick(); pix(100, 300); rnd_px(10);

        do_reset();
        mode_req = 3'd5; set_fg(ONES, 'h80, 'h01);
        tick(); tick(); tick();
        pix(12, 12); pix(44, 12); pix(11, 12); pix(43, 43); pix(12, 44);
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin tick(); pix(12, 12); pix(10, 12); end
        pause = 1'b0;
        for (int i = 0; i < 165; i++) begin
            tick();
            bx = box_pos(m_adv, WIDTH); by = box_pos(m_adv, HEIGHT);
            pix(bx, by); pix(bx + BOX - 1, by + BOX - 1); pix(bx + BOX, by); pix(bx, by + BOX);
            if (bx > 0) pix(bx - 1, by);
            rnd_px(1);
        end

        do_reset();
        mode_req = 3'd5;
        for (int i = 0; i < 25; i++) tick();
        pix(100, 100); pix(110, 110); pix(120, 120);
        reset = 1'b0;
        model_clear();
        #1;
        chk("async_r", int'(r), 0); chk("async_g", int'(g), 0); chk("async_b", int'(b), 0);
        chk("async_mode", int'(mode_active), 0); chk("async_fc", int'(frame_count), 0);
        repeat (2) @(posedge CLOCK_50);
        #1 reset = 1'b1;
        tick(); pix(4, 4); pix(36, 4); pix(0, 0); rnd_px(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
